// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, ID jump and EX branch redirects.
// Optional saturating stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic [3:0]  id_rd,
    input  logic        id_memRead,
    input  logic        id_gt_bra,
    input  logic        id_le_bra,
    input  logic        id_eq_bra,
    input  logic        id_jump,
    input  logic        ex_zero,
    input  logic        ex_neg,
    output logic        pcsrc1,
    output logic        pcsrc2,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        REDIR   = 2'b10
    } hzState_t;

    hzState_t   state;
    hzState_t   nextState;

    logic       exMemRead;
    logic [3:0] exRd;
    logic [2:0] exBra;          // {gt, le, eq}

    logic       branchTaken;
    logic       loadUse;
    logic       jumpTaken;
    logic       stallEvent;
    logic       flushEvent;

    // Every hazard term is qualified by rst_n so reset forces the quiet output set.
    always_comb begin
        branchTaken = rst_n & ((exBra[0] & ex_zero)
                             | (exBra[1] & (ex_zero | ex_neg))
                             | (exBra[2] & ~ex_zero & ~ex_neg));
        loadUse     = rst_n & exMemRead & (exRd != '0)
                    & ((exRd == id_rs) | (exRd == id_rt));
        jumpTaken   = rst_n & id_jump & ~branchTaken & ~loadUse;
        stallEvent  = loadUse & ~branchTaken;
        flushEvent  = jumpTaken | branchTaken;
    end

    always_comb begin
        pcsrc1       = jumpTaken;
        pcsrc2       = branchTaken;
        pc_write     = ~stallEvent;
        if_id_write  = ~stallEvent;
        id_ex_bubble = ~rst_n | branchTaken | loadUse;
    end

    always_comb begin
        nextState = RUN;
        if (flushEvent)
            nextState = REDIR;
        else if (loadUse)
            nextState = LDSTALL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            exMemRead <= 1'b0;
            exRd      <= '0;
            exBra     <= '0;
        end else begin
            state <= nextState;
            if (id_ex_bubble) begin
                exMemRead <= 1'b0;
                exRd      <= '0;
                exBra     <= '0;
            end else begin
                exMemRead <= id_memRead;
                exRd      <= id_rd;
                exBra     <= {id_gt_bra, id_le_bra, id_eq_bra};
            end
        end
    end

    assign hz_state = state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallEvent && stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;
            if (flushEvent && flush_cnt != '1)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use, branches, jump priority, register 0 and reset.
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic        id_memRead, id_gt_bra, id_le_bra, id_eq_bra, id_jump;
    logic        ex_zero, ex_neg;
    logic        pcsrc1, pcsrc2, pc_write, if_id_write, id_ex_bubble;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;
    int expStall = 0;
    int expFlush = 0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_memRead(id_memRead), .id_gt_bra(id_gt_bra), .id_le_bra(id_le_bra),
        .id_eq_bra(id_eq_bra), .id_jump(id_jump),
        .ex_zero(ex_zero), .ex_neg(ex_neg),
        .pcsrc1(pcsrc1), .pcsrc2(pcsrc2), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCtl(input string tag, input logic p1, input logic p2,
                            input logic pw, input logic ifw, input logic bub);
        check({tag, ".pcsrc1"}, {15'd0, pcsrc1}, {15'd0, p1});
        check({tag, ".pcsrc2"}, {15'd0, pcsrc2}, {15'd0, p2});
        check({tag, ".pc_write"}, {15'd0, pc_write}, {15'd0, pw});
        check({tag, ".if_id_write"}, {15'd0, if_id_write}, {15'd0, ifw});
        check({tag, ".bubble"}, {15'd0, id_ex_bubble}, {15'd0, bub});
    endtask

    task automatic checkRegs(input string tag, input logic [1:0] st);
        check({tag, ".hz_state"}, {14'd0, hz_state}, {14'd0, st});
        check({tag, ".stall_cnt"}, stall_cnt, PERF ? 16'(expStall) : 16'd0);
        check({tag, ".flush_cnt"}, flush_cnt, PERF ? 16'(expFlush) : 16'd0);
    endtask

    task automatic setId(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                         input logic mr, input logic gt, input logic le,
                         input logic eq, input logic jmp);
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_memRead = mr; id_gt_bra = gt; id_le_bra = le; id_eq_bra = eq; id_jump = jmp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with a jump pending: all redirects suppressed
        rst_n = 1'b0; ex_zero = 1'b0; ex_neg = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 1);
        #1 checkCtl("rst", 0, 0, 1, 1, 1);
        tick(); tick();
        checkRegs("rst", 2'b00);

        // load-use on rs, with a jump behind it
        rst_n = 1'b1;
        setId(0, 0, 5, 1, 0, 0, 0, 0);
        #1 checkCtl("lu_n", 0, 0, 1, 1, 0);
        tick(); checkRegs("lu_n", 2'b00);
        setId(5, 0, 0, 0, 0, 0, 0, 1);
        #1 checkCtl("lu_n1", 0, 0, 0, 0, 1);
        tick(); expStall = 1; checkRegs("lu_n1", 2'b01);
        #1 checkCtl("lu_n2", 1, 0, 1, 1, 0);
        tick(); expFlush = 1; checkRegs("lu_n2", 2'b10);

        // register 0 never stalls
        setId(0, 0, 0, 1, 0, 0, 0, 0);
        #1 checkCtl("r0_ld", 0, 0, 1, 1, 0);
        tick(); checkRegs("r0_ld", 2'b00);
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkCtl("r0_use", 0, 0, 1, 1, 0);
        tick(); checkRegs("r0_use", 2'b00);

        // load-use on rt
        setId(0, 0, 7, 1, 0, 0, 0, 0);
        tick();
        setId(0, 7, 0, 0, 0, 0, 0, 0);
        #1 checkCtl("rt_use", 0, 0, 0, 0, 1);
        tick(); expStall = 2; checkRegs("rt_use", 2'b01);

        // taken beq; the following cycle sees ex_bra cleared
        setId(0, 0, 0, 0, 0, 0, 1, 0);
        #1 checkCtl("beq_n", 0, 0, 1, 1, 0);
        tick(); checkRegs("beq_n", 2'b00);
        setId(0, 0, 0, 0, 0, 0, 0, 0); ex_zero = 1'b1;
        #1 checkCtl("beq_n1", 0, 1, 1, 1, 1);
        tick(); expFlush = 2; checkRegs("beq_n1", 2'b10);
        #1 checkCtl("beq_n2", 0, 0, 1, 1, 0);
        tick(); checkRegs("beq_n2", 2'b00);
        ex_zero = 1'b0;

        // bgt not taken on negative, then taken on positive
        setId(0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        setId(0, 0, 0, 0, 0, 0, 0, 0); ex_neg = 1'b1;
        #1 checkCtl("bgt_nt", 0, 0, 1, 1, 0);
        tick(); checkRegs("bgt_nt", 2'b00);
        setId(0, 0, 0, 0, 1, 0, 0, 0); ex_neg = 1'b0;
        tick();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkCtl("bgt_t", 0, 1, 1, 1, 1);
        tick(); expFlush = 3; checkRegs("bgt_t", 2'b10);

        // ble taken on negative, not taken on positive
        setId(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        setId(0, 0, 0, 0, 0, 0, 0, 0); ex_neg = 1'b1;
        #1 checkCtl("ble_t", 0, 1, 1, 1, 1);
        tick(); expFlush = 4; ex_neg = 1'b0;
        setId(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        setId(0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkCtl("ble_nt", 0, 0, 1, 1, 0);
        tick(); checkRegs("ble_nt", 2'b00);

        // gt|eq both set, zero result: eq term takes it
        setId(0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        setId(0, 0, 0, 0, 0, 0, 0, 0); ex_zero = 1'b1;
        #1 checkCtl("multi", 0, 1, 1, 1, 1);
        tick(); expFlush = 5; checkRegs("multi", 2'b10);
        ex_zero = 1'b0;

        // branch beats load-use beats jump
        setId(0, 0, 3, 1, 0, 0, 1, 0);
        #1 checkCtl("pri_ld", 0, 0, 1, 1, 0);
        tick();
        setId(3, 0, 0, 0, 0, 0, 0, 1); ex_zero = 1'b1;
        #1 checkCtl("pri", 0, 1, 1, 1, 1);
        tick(); expFlush = 6; checkRegs("pri", 2'b10);
        ex_zero = 1'b0;

        // reset lands on the load-use cycle
        setId(0, 0, 9, 1, 0, 0, 0, 0);
        tick();
        setId(9, 0, 0, 0, 0, 0, 0, 1); rst_n = 1'b0;
        #1 checkCtl("rst_mid", 0, 0, 1, 1, 1);
        tick(); expStall = 0; expFlush = 0; rst_n = 1'b1;
        checkRegs("rst_mid", 2'b00);
        setId(9, 0, 0, 0, 0, 0, 0, 0);
        #1 checkCtl("post_rst", 0, 0, 1, 1, 0);
        tick(); checkRegs("post_rst", 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
